spi_module: RTL and testbench
=============================

Name: spi_module

Overview:
- SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first, bridging an external SPI master to two 32-bit registers in the clk domain.
- Each transaction is 40 bits framed by ncs low: an 8-bit command, then 32 data bits.
- During the command byte the slave returns a status byte on miso; during the data phase it returns the selected register's pre-transaction value.
- sck, mosi and ncs are oversampled by clk through synchronizers; there is no logic clocked by sck.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the sck/mosi/ncs synchronizers (minimum 2).
- STATUS, 8'hA5, constant status byte shifted out during the command phase.
- Q0_RESET, 32'h0, reset value of register 0.
- Q1_RESET, 32'h0, reset value of register 1.

Ports:
- clk  in  1  system clock; must be at least 8x the sck frequency.
- rst  in  1  asynchronous active-high reset.
- sck  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI data from the master, asynchronous.
- ncs  in  1  active-low chip select, asynchronous.
- miso  out  1  SPI data to the master; always driven, never tristated.
- q0  out  32  register 0 contents.
- q1  out  32  register 1 contents.

Behaviour:
- Reset (async, rst=1): synchronizers load idle values (sck=0, mosi=0, ncs=1). Bit counter=0, shift registers=0, miso=0, q0=Q0_RESET, q1=Q1_RESET.
- Synchronization: sck, mosi and ncs each pass through SYNC_STAGES flops. Edge detection compares the last synchronized sck sample with the one before it.
- Idle (synchronized ncs=1):
  - bit counter=0; miso=0; no register changes.
- Transaction start (synchronized ncs falling edge):
  - tx shift register loads {STATUS, 32'h0}.
  - miso drives STATUS[7] within SYNC_STAGES+1 clk cycles, before the first sck rise.
- sck rising edge, ncs low:
  - shift synchronized mosi into the rx shift register LSB.
  - increment the bit counter, saturating at 40.
- 8th rising edge: command complete.
  - cmd[7]=1 means write, 0 means read; cmd[0] selects register 0 or 1; cmd[6:1] are ignored.
  - tx data bits [31:0] load the selected register's current value.
- sck falling edge, ncs low, counter in 1..39: shift the tx register left; miso drives the new MSB.
  - After the 8th falling edge, miso carries data bit 31.
- 40th rising edge: if cmd[7]=1, the 32 received bits are written to the selected register on the next clk. q0/q1 update one clk after that edge.
- After 40 bits while ncs stays low: further edges are ignored and miso=0.
- ncs rising before 40 bits (abort): no write; counter resets; miso returns to 0.
- ncs rising exactly at or after the 40th bit: the committed write stands.
- Read commands never modify registers. Write commands return the old register value on miso during the data phase.
- Simultaneous ncs rise and sck edge in the same clk sample: ncs wins and the edge is ignored.
- rst mid-transaction: immediate return to reset state. Subsequent sck edges are ignored until a fresh ncs falling edge.

Decomposition:
- Shared package holds: CMD_WR_BIT=7, CMD_ADDR_BIT=0, CMD_BITS=8, DATA_BITS=32, FRAME_BITS=40, default STATUS.
- One sub-module, spi_sync: parameterised multi-stage synchronizer with async reset and reset value parameter. Instantiated three times (sck, mosi, ncs).
- Shift registers, counter, decode and register file stay in spi_module.

Test Plan:
- After reset, write: clk period 10, sck half-period 137, cmd 8'hB0, data 32'h24AF55AA. Master samples miso at each sck rise. Required: status 8'hA5, data 32'h00000000, q0=32'h24AF55AA, q1 unchanged 0.
- Read back: cmd 8'h30, any data. Required: status 8'hA5, data 32'h24AF55AA, q0 unchanged.
- Read register 1 after reset: cmd 8'h51, data 32'h01234567. Required: status 8'hA5, data 32'h00000000, q1 stays 0.
- Write then read register 1: cmd 8'h81 with data 32'hDEADBEEF, then cmd 8'h01. Required: second frame returns 32'hDEADBEEF; q0 unaffected.
- Abort: cmd 8'h80, then ncs raised after 20 data bits. Required: q0 unchanged. The next full read of reg0 returns the old value with status 8'hA5.
- Reset mid-frame: rst pulsed after bit 12 of a write. Required: q0/q1 back to reset values, miso=0. A following complete frame behaves normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI register bridge.
package spi_pkg;

    localparam int unsigned CMD_WR_BIT     = 7;
    localparam int unsigned CMD_ADDR_BIT   = 0;
    localparam int unsigned CMD_BITS       = 8;
    localparam int unsigned DATA_BITS      = 32;
    localparam int unsigned FRAME_BITS     = CMD_BITS + DATA_BITS;
    localparam int unsigned CNT_W          = 6;
    localparam logic [7:0]  STATUS_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_WAIT,   // after reset: need a valid ncs-high sample before arming
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage flop synchronizer with async reset to a chosen idle value.
module spi_sync
    import spi_pkg::*;
#(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_module.sv
// Mode-0 SPI slave oversampled by clk: 8-bit command + 32-bit data into two
// registers, returning a status byte and the selected register's old value.
module spi_module
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  STATUS      = STATUS_DEFAULT,
    parameter logic [31:0] Q0_RESET    = 32'h0,
    parameter logic [31:0] Q1_RESET    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        mosi,
    input  logic        ncs,
    output logic        miso,
    output logic [31:0] q0,
    output logic [31:0] q1
);

    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    logic sck_s, mosi_s, ncs_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck
        (.clk(clk), .rst(rst), .d_i(sck),  .q_o(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi
        (.clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs
        (.clk(clk), .rst(rst), .d_i(ncs),  .q_o(ncs_s));

    spi_state_t               state_q, state_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic                     sck_prev_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_BITS-2:0]     rx_q, rx_d;
    logic [FRAME_BITS-1:0]    tx_q, tx_d;
    logic                     miso_q, miso_d;
    logic                     wr_q, wr_d;
    logic                     addr_q, addr_d;
    logic [31:0]              q0_q, q0_d, q1_q, q1_d;

    logic                     sck_rise, sck_fall;
    logic [DATA_BITS-1:0]     rx_word;
    logic [31:0]              sel_val;

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign rx_word  = {rx_q, mosi_s};
    // cmd[0] is the last command bit, so it is the live mosi sample on edge 8
    assign sel_val  = mosi_s ? q1_q : q0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            fill_q     <= '0;
            sck_prev_q <= 1'b0;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 1'b0;
            q0_q       <= Q0_RESET;
            q1_q       <= Q1_RESET;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            sck_prev_q <= sck_s;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        q0_d    = q0_q;
        q1_d    = q1_q;

        // Synchronizer outputs hold reset values until flushed; don't trust ncs before then
        if (fill_q != FILL_W'(SYNC_STAGES)) begin
            fill_d = fill_q + 1'b1;
        end

        unique case (state_q)
            ST_WAIT: begin
                cnt_d  = '0;
                miso_d = 1'b0;
                if (fill_q == FILL_W'(SYNC_STAGES) && ncs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                cnt_d  = '0;
                miso_d = 1'b0;
                if (!ncs_s) begin
                    state_d = ST_SHIFT;
                    tx_d    = {STATUS, {DATA_BITS{1'b0}}};
                    miso_d  = STATUS[7];
                end
            end
            ST_SHIFT: begin
                if (ncs_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                end else if (sck_rise) begin
                    rx_d  = rx_word[DATA_BITS-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        wr_d   = rx_word[CMD_WR_BIT];
                        addr_d = rx_word[CMD_ADDR_BIT];
                        // Seven falling shifts already happened, so data lands below the live MSB
                        tx_d   = {tx_q[FRAME_BITS-1], sel_val, {(CMD_BITS-1){1'b0}}};
                    end
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d = ST_DONE;
                        miso_d  = 1'b0;
                        if (wr_q && addr_q) begin
                            q1_d = rx_word;
                        end else if (wr_q) begin
                            q0_d = rx_word;
                        end
                    end
                end else if (sck_fall && cnt_q != '0) begin
                    tx_d   = tx_q << 1;
                    miso_d = tx_q[FRAME_BITS-2];
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
                if (ncs_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign miso = miso_q;
    assign q0   = q0_q;
    assign q1   = q1_q;

endmodule

// File: tb/tb_spi_module.sv
// Directed bench for spi_module: master-side frame driver plus a register-level model.
module tb_spi_module;

    localparam time TCLK  = 10;
    localparam time THALF = 137;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        ncs = 1'b1;
    logic        miso;
    logic [31:0] q0, q1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mreg [2];
    bit busy = 1'b1;
    logic [39:0] got;

    spi_module dut (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ncs(ncs),
        .miso(miso), .q0(q0), .q1(q1)
    );

    always #(TCLK/2) clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outside frames, registers must equal the model and miso must idle low.
    always @(negedge clk) begin
        if (!busy) begin
            check("q0_model", 64'(q0), 64'(mreg[0]));
            check("q1_model", 64'(q1), 64'(mreg[1]));
            check("miso_idle", 64'(miso), 64'(0));
        end
    end

    // Master: drives nbits MSB-first, samples miso at each sck rise.
    task automatic frame(input logic [7:0] cmd, input logic [31:0] data,
                         input int nbits, input bit raise, output logic [39:0] rx);
        logic [39:0] tx;
        logic [31:0] pre;
        tx   = {cmd, data};
        pre  = mreg[cmd[0]];
        rx   = '0;
        busy = 1'b1;
        ncs  = 1'b0;
        #(THALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[39-i];
            #(THALF);
            sck = 1'b1;
            rx  = {rx[38:0], miso};
            if (i == 39 && cmd[7]) mreg[cmd[0]] = data;
            #(THALF);
            sck = 1'b0;
        end
        if (nbits == 40) check("frame_model", 64'(rx), 64'({8'hA5, pre}));
        #(THALF);
        if (raise) begin
            ncs = 1'b1;
            repeat (10) @(negedge clk);
            busy = 1'b0;
        end
    endtask

    initial begin
        mreg[0] = 32'h0;
        mreg[1] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_q0", 64'(q0), 64'h0);
        check("rst_q1", 64'(q1), 64'h0);
        check("rst_miso", 64'(miso), 64'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        busy = 1'b0;

        frame(8'hB0, 32'h24AF55AA, 40, 1'b1, got);
        check("wr0_status", 64'(got[39:32]), 64'hA5);
        check("wr0_old", 64'(got[31:0]), 64'h0);
        check("wr0_q0", 64'(q0), 64'h24AF55AA);
        check("wr0_q1", 64'(q1), 64'h0);

        frame(8'h30, 32'hFFFFFFFF, 40, 1'b1, got);
        check("rd0_status", 64'(got[39:32]), 64'hA5);
        check("rd0_data", 64'(got[31:0]), 64'h24AF55AA);
        check("rd0_q0", 64'(q0), 64'h24AF55AA);

        frame(8'h51, 32'h01234567, 40, 1'b1, got);
        check("rd1_status", 64'(got[39:32]), 64'hA5);
        check("rd1_data", 64'(got[31:0]), 64'h0);
        check("rd1_q1", 64'(q1), 64'h0);

        frame(8'h81, 32'hDEADBEEF, 40, 1'b1, got);
        frame(8'h01, 32'h00000000, 40, 1'b1, got);
        check("wr1_rd1_data", 64'(got[31:0]), 64'hDEADBEEF);
        check("wr1_q0", 64'(q0), 64'h24AF55AA);
        check("wr1_q1", 64'(q1), 64'hDEADBEEF);

        // abort after 8 command + 20 data bits
        frame(8'h80, 32'h11111111, 28, 1'b1, got);
        check("abort_q0", 64'(q0), 64'h24AF55AA);
        frame(8'h00, 32'h0, 40, 1'b1, got);
        check("abort_rd_status", 64'(got[39:32]), 64'hA5);
        check("abort_rd_data", 64'(got[31:0]), 64'h24AF55AA);

        // reset pulse with ncs held low after 12 bits of a write
        frame(8'h80, 32'h13572468, 12, 1'b0, got);
        rst = 1'b1;
        mreg[0] = 32'h0;
        mreg[1] = 32'h0;
        #1;
        check("midrst_q0", 64'(q0), 64'h0);
        check("midrst_q1", 64'(q1), 64'h0);
        check("midrst_miso", 64'(miso), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        // edges while ncs stays low must be ignored
        for (int i = 0; i < 30; i++) begin
            mosi = i[0];
            #(THALF);
            sck = 1'b1;
            check("midrst_ignored_miso", 64'(miso), 64'h0);
            #(THALF);
            sck = 1'b0;
        end
        check("midrst_ignored_q0", 64'(q0), 64'h0);
        ncs = 1'b1;
        repeat (10) @(negedge clk);
        busy = 1'b0;

        frame(8'h80, 32'hCAFEF00D, 40, 1'b1, got);
        check("post_rst_wr_status", 64'(got[39:32]), 64'hA5);
        check("post_rst_wr_old", 64'(got[31:0]), 64'h0);
        frame(8'h00, 32'h0, 40, 1'b1, got);
        check("post_rst_rd_data", 64'(got[31:0]), 64'hCAFEF00D);
        check("post_rst_q1", 64'(q1), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
